// File: rtl/vector_fill.sv
// Serial count-to-mask generator: fills min(count, DATA_W) contiguous ones from a base
// position with wrap-around, one bit per clock, then presents the vector on a valid/ready port.
module vector_fill #(
  parameter int DATA_W = 10,
  parameter int POS_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [POS_W:0]    in_count,
  input  logic [POS_W-1:0]  in_base,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat,
  output logic              out_err,
  output logic              busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  // Clamp and base checks are done at full count width so counts above 2**POS_W compare correctly
  localparam logic [POS_W:0]   DW_C   = (POS_W+1)'(DATA_W);
  localparam logic [POS_W-1:0] LAST_C = POS_W'(DATA_W - 1);
  localparam logic [POS_W:0]   ONE_C  = (POS_W+1)'(1);

  logic [1:0]        state_q, state_d;
  logic [POS_W-1:0]  ptr_q, ptr_d;
  logic [POS_W:0]    rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              sat_q, sat_d;
  logic              err_q, err_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    sat_d   = sat_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sat_d   = (in_count > DW_C);
          err_d   = ({1'b0, in_base} >= DW_C);
          rem_d   = sat_d ? DW_C : in_count;
          ptr_d   = err_d ? '0 : in_base;
          data_d  = '0;
          state_d = (rem_d != '0) ? FILL : HOLD;
        end
      end
      FILL: begin
        data_d[ptr_q] = 1'b1;
        rem_d         = rem_q - ONE_C;
        // Pointer wraps at DATA_W, not at the natural 2**POS_W boundary
        ptr_d         = (ptr_q == LAST_C) ? '0 : ptr_q + 1'b1;
        if (rem_q == ONE_C) state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_data  = data_q;
  assign out_sat   = sat_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_vector_fill.sv
// Scoreboard bench for vector_fill: driver pushes model-predicted vectors, monitor checks on handshake.
module tb_vector_fill;

  localparam int DW = 10;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [PW:0]   in_count;
  logic [PW-1:0] in_base;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sat;
  logic          out_err;
  logic          busy;

  vector_fill #(.DATA_W(DW), .POS_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count), .in_base(in_base),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          sat;
    logic          err;
    int            lat;
    int            acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rnd_rdy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: set min(c,DW) bits starting at the (sanitised) base, indices taken modulo DW
  function automatic logic [DW-1:0] model_vec(input int c, input int b);
    logic [DW-1:0] v;
    int n, p;
    v = '0;
    n = (c > DW) ? DW : c;
    p = (b >= DW) ? 0 : b;
    for (int i = 0; i < n; i++) v[(p + i) % DW] = 1'b1;
    return v;
  endfunction

  task automatic send(input int c, input int b);
    exp_t e;
    bit   got;
    got = 0;
    in_count = c[PW:0];
    in_base  = b[PW-1:0];
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (in_ready) begin
        e.data = model_vec(c, b);
        e.sat  = (c > DW);
        e.err  = (b >= DW);
        e.lat  = (c > DW) ? DW : c;
        e.acc  = cyc + 1;
        sb.push_back(e);
        got = 1;
      end
      @(posedge clk); #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    if (!got) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && sb.size() != 0; n++) @(posedge clk);
    chk("drain_empty", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: compares on every output handshake, also checks the vector stays put while stalled
  initial begin
    exp_t          e;
    bit            seen;
    int            first;
    logic [DW-1:0] held;
    seen = 0;
    first = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) seen = 0;
      else if (out_valid) begin
        if (!seen) begin
          seen = 1; first = cyc; held = out_data;
        end else chk("hold_stable", out_data, held);
        if (out_ready) begin
          if (sb.size() == 0) chk("unexpected_output", 1, 0);
          else begin
            e = sb.pop_front();
            chk("data", out_data, e.data);
            chk("sat", out_sat, e.sat);
            chk("err", out_err, e.err);
            chk("latency", first - e.acc, e.lat);
            chk("popcount", $countones(out_data), e.lat);
          end
          seen = 0;
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] stall_exp;
    bit            vseen;
    rst_n = 1'b0; in_valid = 1'b0; in_count = '0; in_base = '0; out_ready = 1'b1;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sat_err", {out_sat, out_err}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    send(3, 0);  drain();
    send(4, 8);  drain();
    send(0, 5);  drain();
    send(15, 3); drain();
    send(2, 12); drain();

    // Output stall: in_valid pulses must be ignored while the result is held
    out_ready = 1'b0;
    send(5, 7);
    stall_exp = model_vec(5, 7);
    vseen = 0;
    for (int n = 0; n < 50 && !vseen; n++) begin
      @(negedge clk);
      vseen = out_valid;
    end
    chk("stall_valid", vseen, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_valid = (k % 2 == 0);
      in_count = 5'($urandom_range(0, 31));
      in_base  = 4'($urandom_range(0, 15));
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_data", out_data, stall_exp);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(1, 9);
    send(10, 0);
    send(DW, 6);
    drain();

    // Asynchronous reset during FILL drops the partial result
    send(15, 12);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_sat_err", {out_sat, out_err}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);

    rnd_rdy = 1;
    for (int r = 0; r < 60; r++) send($urandom_range(0, 31), $urandom_range(0, 15));
    rnd_rdy = 0;
    out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
